// File: rtl/kernel_mem_responder.sv
// Memory-side responder for the kernel wrapper's single-word read/write protocol.
// Serves requests from a word scratchpad after a fixed latency and answers with one-cycle ready pulses.
module kernel_mem_responder #(
   parameter int unsigned ADDR_WID = 16,
   parameter int unsigned DATA_WID = 32,
   parameter logic [63:0] MEM_BASE = 64'd0,
   parameter int unsigned RD_LAT   = 2,
   parameter int unsigned WR_LAT   = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                read_enable,
   input  logic [63:0]         read_addr,
   input  logic [63:0]         read_size,
   input  logic                write_enable,
   input  logic [63:0]         write_addr,
   input  logic [DATA_WID-1:0] write_data,
   input  logic [63:0]         write_size,
   input  logic                finish_read,
   input  logic                finish_write,
   input  logic                init_we,
   input  logic [ADDR_WID-1:0] init_addr,
   input  logic [DATA_WID-1:0] init_data,
   output logic [63:0]         read_ready,
   output logic [DATA_WID-1:0] read_data,
   output logic [63:0]         write_ready,
   output logic [31:0]         rd_count,
   output logic [31:0]         wr_count,
   output logic                err
);

   // state   | meaning
   // IDLE    | accepting strobes and host preload writes
   // RD_WAIT | read latency countdown
   // RD_RESP | read_ready pulse, read_data valid
   // WR_WAIT | write latency countdown
   // WR_RESP | write_ready pulse, word committed; may chain into a pending read
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_WAIT = 3'd1;
   localparam logic [2:0] RD_RESP = 3'd2;
   localparam logic [2:0] WR_WAIT = 3'd3;
   localparam logic [2:0] WR_RESP = 3'd4;

   localparam logic [7:0] RD_CNT_INIT = 8'(RD_LAT - 1);
   localparam logic [7:0] WR_CNT_INIT = 8'(WR_LAT - 1);
   localparam logic [2:0] RD_FIRST    = (RD_LAT == 1) ? RD_RESP : RD_WAIT;
   localparam logic [2:0] WR_FIRST    = (WR_LAT == 1) ? WR_RESP : WR_WAIT;

   logic [DATA_WID-1:0] mem [0:(1 << ADDR_WID) - 1];

   logic [2:0]          state, state_nxt;
   logic [7:0]          cnt, cnt_nxt;
   logic                pend_rd;
   logic [ADDR_WID-1:0] rd_idx_q, wr_idx_q;
   logic                rd_oor_q, wr_oor_q;
   logic [DATA_WID-1:0] wr_data_q;

   logic [63:0]         rd_off, wr_off;
   logic                rd_req_oor, wr_req_oor;
   logic [ADDR_WID-1:0] rd_req_idx, wr_req_idx;
   logic [ADDR_WID-1:0] rd_src_idx, wr_src_idx;
   logic                rd_src_oor, wr_src_oor;
   logic [DATA_WID-1:0] wr_src_data;
   logic                rd_fire, wr_fire, err_evt;
   logic                unused_info;

   assign unused_info = finish_read ^ finish_write;

   assign rd_off     = read_addr - MEM_BASE;
   assign wr_off     = write_addr - MEM_BASE;
   assign rd_req_oor = (read_addr < MEM_BASE) || (read_addr[1:0] != 2'b00) ||
                       (rd_off[1:0] != 2'b00) || (rd_off[63:ADDR_WID+2] != '0);
   assign wr_req_oor = (write_addr < MEM_BASE) || (write_addr[1:0] != 2'b00) ||
                       (wr_off[1:0] != 2'b00) || (wr_off[63:ADDR_WID+2] != '0);
   assign rd_req_idx = rd_off[ADDR_WID+1:2];
   assign wr_req_idx = wr_off[ADDR_WID+1:2];

   // With a latency of 1 the response fires on the accepting edge, so bypass the latches
   assign rd_src_idx  = (state == IDLE) ? rd_req_idx : rd_idx_q;
   assign rd_src_oor  = (state == IDLE) ? rd_req_oor : rd_oor_q;
   assign wr_src_idx  = (state == IDLE) ? wr_req_idx : wr_idx_q;
   assign wr_src_oor  = (state == IDLE) ? wr_req_oor : wr_oor_q;
   assign wr_src_data = (state == IDLE) ? write_data : wr_data_q;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (write_enable) begin
               cnt_nxt   = WR_CNT_INIT;
               state_nxt = WR_FIRST;
            end else if (read_enable) begin
               cnt_nxt   = RD_CNT_INIT;
               state_nxt = RD_FIRST;
            end
         end
         RD_WAIT: begin
            cnt_nxt = cnt - 8'd1;
            if (cnt <= 8'd1) state_nxt = RD_RESP;
         end
         WR_WAIT: begin
            cnt_nxt = cnt - 8'd1;
            if (cnt <= 8'd1) state_nxt = WR_RESP;
         end
         RD_RESP: state_nxt = IDLE;
         WR_RESP: begin
            if (pend_rd) begin
               cnt_nxt   = RD_CNT_INIT;
               state_nxt = RD_FIRST;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Response-state entry is where data moves, so read_data is valid during the pulse
   assign rd_fire = (state_nxt == RD_RESP);
   assign wr_fire = (state_nxt == WR_RESP);

   assign err_evt = (state == IDLE) ?
                    ((read_enable  && (rd_req_oor || (read_size  != 64'd4))) ||
                     (write_enable && (wr_req_oor || (write_size != 64'd4)))) :
                    (read_enable || write_enable || init_we);

   assign read_ready  = {63'd0, state == RD_RESP};
   assign write_ready = {63'd0, state == WR_RESP};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         pend_rd   <= 1'b0;
         rd_idx_q  <= '0;
         rd_oor_q  <= 1'b0;
         wr_idx_q  <= '0;
         wr_oor_q  <= 1'b0;
         wr_data_q <= '0;
         read_data <= '0;
         rd_count  <= 32'd0;
         wr_count  <= 32'd0;
         err       <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if ((state == IDLE) && write_enable) begin
            wr_idx_q  <= wr_req_idx;
            wr_oor_q  <= wr_req_oor;
            wr_data_q <= write_data;
            pend_rd   <= read_enable;
         end else if (state == WR_RESP) begin
            pend_rd <= 1'b0;
         end
         if ((state == IDLE) && read_enable) begin
            rd_idx_q <= rd_req_idx;
            rd_oor_q <= rd_req_oor;
         end
         if (rd_fire) begin
            read_data <= rd_src_oor ? '0 : mem[rd_src_idx];
            rd_count  <= rd_count + 32'd1;
         end
         if (wr_fire) wr_count <= wr_count + 32'd1;
         if (err_evt) err <= 1'b1;
      end
   end

   // Scratchpad has no reset; writes are blocked while reset is held so contents survive it
   always_ff @(posedge clk) begin
      if (reset && wr_fire && !wr_src_oor) begin
         mem[wr_src_idx] <= wr_src_data;
      end else if (reset && init_we && (state == IDLE)) begin
         mem[init_addr] <= init_data;
      end
   end

endmodule

// File: tb/tb_kernel_mem_responder.sv
// Scoreboard bench for kernel_mem_responder: two instances (default latencies, and RD_LAT=1/WR_LAT=3)
// driven by the same directed stimulus, each with its own expected-response queues.
module tb_kernel_mem_responder;

   localparam int A_RD = 2;
   localparam int A_WR = 1;
   localparam int B_RD = 1;
   localparam int B_WR = 3;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        read_enable, write_enable, finish_read, finish_write, init_we;
   logic [63:0] read_addr, read_size, write_addr, write_size;
   logic [31:0] write_data, init_data;
   logic [15:0] init_addr;

   logic [63:0] a_read_ready, a_write_ready, b_read_ready, b_write_ready;
   logic [31:0] a_read_data, a_rd_count, a_wr_count, b_read_data, b_rd_count, b_wr_count;
   logic        a_err, b_err;

   exp_t q_rd_a[$], q_wr_a[$], q_rd_b[$], q_wr_b[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   kernel_mem_responder dut_a (
      .clk(clk), .reset(reset),
      .read_enable(read_enable), .read_addr(read_addr), .read_size(read_size),
      .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
      .write_size(write_size), .finish_read(finish_read), .finish_write(finish_write),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
      .read_ready(a_read_ready), .read_data(a_read_data), .write_ready(a_write_ready),
      .rd_count(a_rd_count), .wr_count(a_wr_count), .err(a_err)
   );

   kernel_mem_responder #(.RD_LAT(B_RD), .WR_LAT(B_WR)) dut_b (
      .clk(clk), .reset(reset),
      .read_enable(read_enable), .read_addr(read_addr), .read_size(read_size),
      .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
      .write_size(write_size), .finish_read(finish_read), .finish_write(finish_write),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
      .read_ready(b_read_ready), .read_data(b_read_data), .write_ready(b_write_ready),
      .rd_count(b_rd_count), .wr_count(b_wr_count), .err(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pulse(input string tag, input logic [63:0] rdy, input logic [31:0] data,
                            input exp_t e, input bit use_data);
      chk({tag, "_ready"}, rdy, 64'd1);
      chk({tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
      if (use_data) chk({tag, "_data"}, {32'd0, data}, {32'd0, e.data});
   endtask

   // One clock; outputs sampled on the falling edge, any pulse must match the queue head
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (a_read_ready !== 64'd0) begin
         chk("a_rd_expected", {63'd0, q_rd_a.size() != 0}, 64'd1);
         if (q_rd_a.size() != 0) begin e = q_rd_a.pop_front(); chk_pulse("a_rd", a_read_ready, a_read_data, e, 1'b1); end
      end
      if (a_write_ready !== 64'd0) begin
         chk("a_wr_expected", {63'd0, q_wr_a.size() != 0}, 64'd1);
         if (q_wr_a.size() != 0) begin e = q_wr_a.pop_front(); chk_pulse("a_wr", a_write_ready, 32'd0, e, 1'b0); end
      end
      if (b_read_ready !== 64'd0) begin
         chk("b_rd_expected", {63'd0, q_rd_b.size() != 0}, 64'd1);
         if (q_rd_b.size() != 0) begin e = q_rd_b.pop_front(); chk_pulse("b_rd", b_read_ready, b_read_data, e, 1'b1); end
      end
      if (b_write_ready !== 64'd0) begin
         chk("b_wr_expected", {63'd0, q_wr_b.size() != 0}, 64'd1);
         if (q_wr_b.size() != 0) begin e = q_wr_b.pop_front(); chk_pulse("b_wr", b_write_ready, 32'd0, e, 1'b0); end
      end
   endtask

   task automatic drain();
      int pending;
      for (int i = 0; i < 50; i++) begin
         if (q_rd_a.size() + q_wr_a.size() + q_rd_b.size() + q_wr_b.size() == 0) break;
         cycle();
      end
      pending = q_rd_a.size() + q_wr_a.size() + q_rd_b.size() + q_wr_b.size();
      chk("drain_pending", 64'(pending), 64'd0);
      q_rd_a.delete(); q_wr_a.delete(); q_rd_b.delete(); q_wr_b.delete();
      for (int i = 0; i < 3; i++) cycle();
   endtask

   task automatic push(input int which, input int at, input logic [31:0] data);
      exp_t e;
      e.cyc  = at;
      e.data = data;
      case (which)
         0: q_rd_a.push_back(e);
         1: q_wr_a.push_back(e);
         2: q_rd_b.push_back(e);
         default: q_wr_b.push_back(e);
      endcase
   endtask

   task automatic issue_rd(input logic [63:0] addr, input logic [63:0] size,
                           input logic [31:0] exp_a, input logic [31:0] exp_b);
      read_enable = 1'b1; read_addr = addr; read_size = size;
      push(0, cyc + A_RD, exp_a);
      push(2, cyc + B_RD, exp_b);
      cycle();
      read_enable = 1'b0; read_size = 64'd4;
   endtask

   task automatic issue_wr(input logic [63:0] addr, input logic [31:0] data, input bit expect_b);
      write_enable = 1'b1; write_addr = addr; write_data = data;
      push(1, cyc + A_WR, 32'd0);
      if (expect_b) push(3, cyc + B_WR, 32'd0);
      cycle();
      write_enable = 1'b0;
   endtask

   task automatic issue_both(input logic [63:0] addr, input logic [31:0] data);
      read_enable = 1'b1; read_addr = addr;
      write_enable = 1'b1; write_addr = addr; write_data = data;
      push(1, cyc + A_WR, 32'd0);
      push(0, cyc + A_WR + A_RD, data);
      push(3, cyc + B_WR, 32'd0);
      push(2, cyc + B_WR + B_RD, data);
      cycle();
      read_enable = 1'b0; write_enable = 1'b0;
   endtask

   task automatic preload(input logic [15:0] idx, input logic [31:0] data);
      init_we = 1'b1; init_addr = idx; init_data = data;
      cycle();
      init_we = 1'b0;
   endtask

   task automatic rst_seq();
      reset = 1'b0;
      cycle();
      chk("rst_a_read_ready", a_read_ready, 64'd0);
      chk("rst_a_write_ready", a_write_ready, 64'd0);
      chk("rst_a_read_data", {32'd0, a_read_data}, 64'd0);
      chk("rst_a_rd_count", {32'd0, a_rd_count}, 64'd0);
      chk("rst_a_wr_count", {32'd0, a_wr_count}, 64'd0);
      chk("rst_a_err", {63'd0, a_err}, 64'd0);
      chk("rst_b_read_data", {32'd0, b_read_data}, 64'd0);
      chk("rst_b_err", {63'd0, b_err}, 64'd0);
      cycle();
      reset = 1'b1;
      cycle();
   endtask

   initial begin
      reset = 1'b0;
      read_enable = 1'b0; write_enable = 1'b0; init_we = 1'b0;
      finish_read = 1'b0; finish_write = 1'b0;
      read_addr = 64'd0; write_addr = 64'd0; read_size = 64'd4; write_size = 64'd4;
      write_data = 32'd0; init_data = 32'd0; init_addr = 16'd0;

      rst_seq();
      preload(16'd5, 32'hDEADBEEF);
      preload(16'd1, 32'h11111111);
      preload(16'd0, 32'h0BAD0000);
      preload(16'd12, 32'h0C0C0C0C);

      // preloaded word read at byte 20
      issue_rd(64'd20, 64'd4, 32'hDEADBEEF, 32'hDEADBEEF);
      drain();
      chk("t1_a_rd_count", {32'd0, a_rd_count}, 64'd1);
      chk("t1_b_rd_count", {32'd0, b_rd_count}, 64'd1);
      chk("t1_a_err", {63'd0, a_err}, 64'd0);

      // write then read back
      issue_wr(64'd40, 32'h12345678, 1'b1);
      drain();
      issue_rd(64'd40, 64'd4, 32'h12345678, 32'h12345678);
      drain();
      chk("t2_a_wr_count", {32'd0, a_wr_count}, 64'd1);
      chk("t2_a_rd_count", {32'd0, a_rd_count}, 64'd2);
      chk("t2_b_wr_count", {32'd0, b_wr_count}, 64'd1);

      // simultaneous write and read, write served first
      issue_both(64'd8, 32'hA5A5A5A5);
      drain();
      chk("t3_a_rd_count", {32'd0, a_rd_count}, 64'd3);
      chk("t3_a_wr_count", {32'd0, a_wr_count}, 64'd2);
      chk("t3_a_data_held", {32'd0, a_read_data}, 64'hA5A5A5A5);
      chk("t3_b_data_held", {32'd0, b_read_data}, 64'hA5A5A5A5);
      chk("t3_a_err", {63'd0, a_err}, 64'd0);

      // misaligned read: answered with zero, err set
      rst_seq();
      issue_rd(64'd6, 64'd4, 32'd0, 32'd0);
      drain();
      chk("t4_mis_a_err", {63'd0, a_err}, 64'd1);
      chk("t4_mis_b_err", {63'd0, b_err}, 64'd1);

      // read past the end of the scratchpad: index would alias word 0
      rst_seq();
      issue_rd(64'd4 << 16, 64'd4, 32'd0, 32'd0);
      drain();
      chk("t4_oor_a_err", {63'd0, a_err}, 64'd1);
      for (int i = 0; i < 5; i++) cycle();
      chk("t4_sticky_a_err", {63'd0, a_err}, 64'd1);
      chk("t4_sticky_b_err", {63'd0, b_err}, 64'd1);

      // illegal size is served but flagged; array survived the resets
      rst_seq();
      issue_rd(64'd20, 64'd8, 32'hDEADBEEF, 32'hDEADBEEF);
      drain();
      chk("t5_size_a_err", {63'd0, a_err}, 64'd1);

      // second strobe while busy is dropped
      rst_seq();
      issue_rd(64'd20, 64'd4, 32'hDEADBEEF, 32'hDEADBEEF);
      read_enable = 1'b1; read_addr = 64'd40;
      cycle();
      read_enable = 1'b0;
      drain();
      chk("t6_a_err", {63'd0, a_err}, 64'd1);
      chk("t6_b_err", {63'd0, b_err}, 64'd1);
      chk("t6_a_rd_count", {32'd0, a_rd_count}, 64'd1);
      chk("t6_b_rd_count", {32'd0, b_rd_count}, 64'd1);

      // reset while dut_b waits on its write: no pulse, word untouched
      rst_seq();
      issue_wr(64'd48, 32'h00000077, 1'b0);
      reset = 1'b0;
      cycle();
      chk("t7_b_write_ready", b_write_ready, 64'd0);
      chk("t7_b_read_ready", b_read_ready, 64'd0);
      chk("t7_b_read_data", {32'd0, b_read_data}, 64'd0);
      chk("t7_b_wr_count", {32'd0, b_wr_count}, 64'd0);
      chk("t7_b_rd_count", {32'd0, b_rd_count}, 64'd0);
      chk("t7_b_err", {63'd0, b_err}, 64'd0);
      cycle();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) cycle();
      issue_rd(64'd48, 64'd4, 32'h00000077, 32'h0C0C0C0C);
      drain();
      chk("t7_b_rd_count_after", {32'd0, b_rd_count}, 64'd1);
      chk("t7_b_wr_count_after", {32'd0, b_wr_count}, 64'd0);
      chk("t7_b_err_after", {63'd0, b_err}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
